// File: rtl/secbuf_pkg.sv
// rtl/secbuf_pkg.sv - shared state encoding and constants for the secure drain FIFO
package secbuf_pkg;

   // CHECK is only entered when the build defines SCRUB_CHECK_EN
   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      SCRUB  = 2'd1,
      CHECK  = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 4;

   localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/secure_regfile.sv
// rtl/secure_regfile.sv - DEPTH x DATA_W storage with write port, zeroize port, read mux and OR-reduce
import secbuf_pkg::*;

module secure_regfile #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ze,
   input  logic [ADDR_W-1:0] zaddr,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] or_all
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage update; the zeroize assignment comes last so it wins on an address clash
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         if (ze) begin
            mem[zaddr] <= DATA_W'(ZERO_WORD);
         end
      end
   end

   assign rdata = mem[raddr];

   // OR of every entry; any residue after a scrub shows up as a non-zero result
   always_comb begin
      or_all = '0;
      for (int i = 0; i < DEPTH; i++) begin
         or_all = or_all | mem[i];
      end
   end

endmodule

// File: rtl/secure_drain_fifo.sv
// rtl/secure_drain_fifo.sv - zeroize-on-pop FIFO with flush scrub; SCRUB_CHECK_EN adds a post-scrub check
import secbuf_pkg::*;

module secure_drain_fifo #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   input  logic              flush,
   output logic              scrub_busy,
   output logic [ADDR_W:0]   count,
   output logic              scrub_err
);

   state_t            state;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] scrub_idx;
   logic [ADDR_W:0]   count_q;
   logic              active;
   logic              scrubbing;
   logic              push;
   logic              pop;
   logic              rf_ze;
   logic [ADDR_W-1:0] rf_zaddr;
   logic [DATA_W-1:0] rf_rdata;
   logic [DATA_W-1:0] rf_or_all;

   assign active     = (state == ACTIVE);
   assign scrubbing  = (state == SCRUB);
   assign wr_ready   = rst & active & ~flush & (count_q < (ADDR_W+1)'(DEPTH));
   assign rd_valid   = active & ~flush & (count_q != '0);
   assign rd_data    = rd_valid ? rf_rdata : '0;
   assign scrub_busy = ~active;
   assign count      = count_q;
   assign push       = wr_valid & wr_ready;
   assign pop        = rd_valid & rd_ready;

   // Pop and scrub share the zeroize port; they never overlap because pop needs ACTIVE
   assign rf_ze    = pop | scrubbing;
   assign rf_zaddr = scrubbing ? scrub_idx : rd_ptr;

   secure_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (push),
      .waddr  (wr_ptr),
      .wdata  (wr_data),
      .ze     (rf_ze),
      .zaddr  (rf_zaddr),
      .raddr  (rd_ptr),
      .rdata  (rf_rdata),
      .or_all (rf_or_all)
   );

`ifdef SCRUB_CHECK_EN
   logic scrub_err_q;
   assign scrub_err = scrub_err_q;
`else
   logic [DATA_W-1:0] unused_or_all;
   assign unused_or_all = rf_or_all;
   assign scrub_err     = 1'b0;
`endif

   // Control FSM: pointer/count tracking in ACTIVE, one-entry-per-cycle scrub after a flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACTIVE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         scrub_idx <= '0;
         count_q   <= '0;
`ifdef SCRUB_CHECK_EN
         scrub_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            ACTIVE: begin
               if (flush) begin
                  rd_ptr    <= '0;
                  wr_ptr    <= '0;
                  scrub_idx <= '0;
                  count_q   <= '0;
                  state     <= SCRUB;
`ifdef SCRUB_CHECK_EN
                  scrub_err_q <= 1'b0;
`endif
               end else begin
                  if (push) begin
                     wr_ptr <= wr_ptr + ADDR_W'(1);
                  end
                  if (pop) begin
                     rd_ptr <= rd_ptr + ADDR_W'(1);
                  end
                  if (push && !pop) begin
                     count_q <= count_q + (ADDR_W+1)'(1);
                  end else if (pop && !push) begin
                     count_q <= count_q - (ADDR_W+1)'(1);
                  end
               end
            end
            SCRUB: begin
               scrub_idx <= scrub_idx + ADDR_W'(1);
               if (scrub_idx == ADDR_W'(DEPTH - 1)) begin
`ifdef SCRUB_CHECK_EN
                  state <= CHECK;
`else
                  state <= ACTIVE;
`endif
               end
            end
`ifdef SCRUB_CHECK_EN
            CHECK: begin
               if (rf_or_all != '0) begin
                  scrub_err_q <= 1'b1;
               end
               state <= ACTIVE;
            end
`endif
            default: begin
               state <= ACTIVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secure_drain_fifo.sv
// tb/tb_secure_drain_fifo.sv - directed self-checking bench for secure_drain_fifo
module tb_secure_drain_fifo;

`ifdef SCRUB_CHECK_EN
   localparam int EXP_BUSY = 5;
`else
   localparam int EXP_BUSY = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_ready = 1'b0;
   logic       flush = 1'b0;
   logic       scrub_busy;
   logic [2:0] count;
   logic       scrub_err;

   int n_vec  = 0;
   int n_miss = 0;

   secure_drain_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_ready   (rd_ready),
      .flush      (flush),
      .scrub_busy (scrub_busy),
      .count      (count),
      .scrub_err  (scrub_err)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem_zero(input string tag);
      for (int i = 0; i < 4; i++) begin
         check_vec($sformatf("%s_mem%0d", tag, i), 32'(dut.u_regfile.mem[i]), 32'h0);
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int busy;
      int guard;

      // reset state
      #12;
      check_vec("rst_wr_ready", 32'(wr_ready), 32'h0);
      check_vec("rst_rd_valid", 32'(rd_valid), 32'h0);
      check_vec("rst_rd_data", 32'(rd_data), 32'h0);
      check_vec("rst_busy", 32'(scrub_busy), 32'h0);
      check_vec("rst_count", 32'(count), 32'h0);
      check_vec("rst_err", 32'(scrub_err), 32'h0);
      tick();
      rst = 1'b1;
      #1;
      check_vec("rel_wr_ready", 32'(wr_ready), 32'h1);

      // push A5, 3C then pop both
      wr_valid = 1'b1; wr_data = 8'hA5; tick();
      check_vec("lat_rd_data", 32'(rd_data), 32'hA5);
      wr_data = 8'h3C; tick();
      wr_valid = 1'b0;
      check_vec("p2_count", 32'(count), 32'h2);
      rd_ready = 1'b1;
      check_vec("pop1_data", 32'(rd_data), 32'hA5);
      tick();
      check_vec("pop2_data", 32'(rd_data), 32'h3C);
      check_vec("pop1_count", 32'(count), 32'h1);
      check_vec("pop1_zero", 32'(dut.u_regfile.mem[0]), 32'h0);
      tick();
      rd_ready = 1'b0;
      check_vec("empty_rd_valid", 32'(rd_valid), 32'h0);
      check_vec("empty_rd_data", 32'(rd_data), 32'h0);
      check_vec("empty_count", 32'(count), 32'h0);
      check_mem_zero("drained");

      // fill to full, overflow attempt, pop one
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'h11 * (i + 1)); tick();
      end
      check_vec("full_count", 32'(count), 32'h4);
      check_vec("full_wr_ready", 32'(wr_ready), 32'h0);
      wr_data = 8'h55; tick();
      wr_valid = 1'b0;
      check_vec("ovf_count", 32'(count), 32'h4);
      check_vec("full_head", 32'(rd_data), 32'h11);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      check_vec("after_pop_wr_ready", 32'(wr_ready), 32'h1);
      check_vec("after_pop_count", 32'(count), 32'h3);
      check_vec("after_pop_head", 32'(rd_data), 32'h22);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      check_vec("cnt2", 32'(count), 32'h2);

      // simultaneous push/pop across pointer wrap
      q.push_back(8'h33);
      q.push_back(8'h44);
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'h60 + i); rd_ready = 1'b1;
         check_vec($sformatf("sim%0d_data", i), 32'(rd_data), 32'(q[0]));
         tick();
         void'(q.pop_front());
         q.push_back(8'(8'h60 + i));
         check_vec($sformatf("sim%0d_count", i), 32'(count), 32'h2);
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_vec($sformatf("drain%0d_data", i), 32'(rd_data), 32'(q[0]));
         tick();
         void'(q.pop_front());
      end
      rd_ready = 1'b0;
      check_vec("drain_count", 32'(count), 32'h0);

      // fill with FF, flush with both handshakes requested
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 8'hFF; tick();
      end
      wr_data = 8'h77; rd_ready = 1'b1; flush = 1'b1;
      #1;
      check_vec("fl_wr_ready", 32'(wr_ready), 32'h0);
      check_vec("fl_rd_valid", 32'(rd_valid), 32'h0);
      check_vec("fl_rd_data", 32'(rd_data), 32'h0);
      tick();
      flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      busy = 0;
      guard = 0;
      while (scrub_busy === 1'b1 && guard < 20) begin
         busy++;
         guard++;
         check_vec($sformatf("scrub%0d_rd_data", busy), 32'(rd_data), 32'h0);
         flush = (busy == 2);
         tick();
      end
      flush = 1'b0;
      check_vec("scrub_busy_cycles", 32'(busy), 32'(EXP_BUSY));
      check_vec("scrub_count", 32'(count), 32'h0);
      check_vec("scrub_err", 32'(scrub_err), 32'h0);
      check_vec("scrub_done_busy", 32'(scrub_busy), 32'h0);
      check_vec("scrub_wr_ready", 32'(wr_ready), 32'h1);
      check_mem_zero("scrubbed");

      // reset in the middle of a scrub
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'hA1 + i); tick();
      end
      wr_valid = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
      tick();
      tick();
      check_vec("mid_busy", 32'(scrub_busy), 32'h1);
      check_vec("mid_mem3", 32'(dut.u_regfile.mem[3]), 32'hA4);
      rst = 1'b0;
      #1;
      check_vec("arst_busy", 32'(scrub_busy), 32'h0);
      check_vec("arst_wr_ready", 32'(wr_ready), 32'h0);
      check_vec("arst_count", 32'(count), 32'h0);
      check_vec("arst_rd_data", 32'(rd_data), 32'h0);
      check_mem_zero("arst");
      tick();
      rst = 1'b1;
      #1;
      check_vec("rel2_wr_ready", 32'(wr_ready), 32'h1);
      check_vec("rel2_count", 32'(count), 32'h0);
      tick();
      check_vec("rel2_busy", 32'(scrub_busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/secure_drain_fifo.md
Name: secure_drain_fifo

Overview:
- Read-side counterpart to the sensitive-data capture stage: accepts captured bytes from the producer and drains them to a consumer over a valid/ready handshake.
- Every storage entry is zeroized on the same edge it is popped, so no stale secret survives reuse.
- A flush request runs a scrub state machine that zeroizes the whole array before the buffer is reused.
- Sits between the capture register stage and any downstream consumer of sensitive bytes.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_valid  input  1  producer has a word.
- wr_data  input  DATA_W  producer word.
- wr_ready  output  1  buffer accepts a word this cycle.
- rd_valid  output  1  a word is presented to the consumer.
- rd_data  output  DATA_W  presented word; all-zero whenever rd_valid=0.
- rd_ready  input  1  consumer accepts the word.
- flush  input  1  request a full scrub.
- scrub_busy  output  1  scrub in progress.
- count  output  ADDR_W+1  number of occupied entries.
- scrub_err  output  1  scrub verification failure; sticky.

Behaviour:
- Reset (rst=0, asynchronous):
  - All mem entries, rd_ptr, wr_ptr, count and scrub_idx clear to 0; state=ACTIVE; scrub_err=0.
  - Outputs during reset: wr_ready=0, rd_valid=0, rd_data=0, scrub_busy=0, count=0.
  - A reset that arrives mid-scrub aborts the scrub and clears everything immediately.
- States:
  - ACTIVE: normal operation.
  - SCRUB: zeroizes the array one entry per cycle.
  - CHECK: present only with SCRUB_CHECK_EN.
- Combinational outputs:
  - wr_ready = rst & ACTIVE & !flush & (count<DEPTH).
  - rd_valid = ACTIVE & !flush & (count>0).
  - rd_data = rd_valid ? mem[rd_ptr] : 0.
  - scrub_busy = (state!=ACTIVE).
- Push: when wr_valid & wr_ready, mem[wr_ptr]<=wr_data and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Pop: when rd_valid & rd_ready, mem[rd_ptr]<=0 on the same edge and rd_ptr increments with wrap.
- Latency: zero-cycle presentation; a word written at edge N is visible on rd_data after edge N.
- Simultaneous push and pop: count is unchanged.
- Pointer collision cannot occur:
  - when full, wr_ready=0 (no write-through bypass);
  - when empty, rd_valid=0.
- Flush:
  - flush=1 in ACTIVE takes priority; no push or pop is accepted that cycle.
  - On edge E0: count, rd_ptr, wr_ptr and scrub_idx clear to 0; state<=SCRUB.
- SCRUB:
  - Edges E1..E_DEPTH each write mem[scrub_idx]<=0, then scrub_idx++.
  - At E_DEPTH, state<=ACTIVE (or CHECK).
  - scrub_busy is high for exactly DEPTH cycles.
  - flush is ignored while in SCRUB or CHECK.
- Count arithmetic: count is ADDR_W+1 bits and never exceeds DEPTH or goes below 0.

Optional Feature:
- SCRUB_CHECK_EN defined:
  - After SCRUB the block enters CHECK for one cycle and ORs all entries together.
  - A non-zero result sets scrub_err=1 (sticky until the next flush or reset), then state<=ACTIVE.
  - scrub_busy is high for DEPTH+1 cycles.
  - scrub_err clears at flush acceptance (E0).
- SCRUB_CHECK_EN undefined:
  - No CHECK state exists; scrub_err is tied to 0.
  - scrub_busy is high for DEPTH cycles.

Decomposition:
- Package secbuf_pkg holds:
  - the state enum {ACTIVE, SCRUB, CHECK};
  - the default DATA_W and DEPTH constants;
  - the zero-word constant.
- Sub-module secure_regfile: DEPTH x DATA_W array with one write port and one zeroize port (zeroize wins when both target the same address), a read mux, and an OR-reduction output for CHECK.
- The FSM and pointer logic live in the top level.

Test Plan:
- Reset then push 0xA5, 0x3C; pop both with rd_ready=1 -> rd_data shows 0xA5 then 0x3C; afterwards the internal entries read 0x00, rd_valid=0, rd_data=0x00, count=0.
- Push 4 words (0x11..0x44) -> count=4, wr_ready=0; a 5th wr_valid is not accepted; pop one -> wr_ready=1 next cycle.
- Count=2, hold wr_valid=1 and rd_ready=1 for 6 cycles -> count stays 2; pointers wrap past 3 to 0 and data order is preserved.
- Fill with 0xFF, assert flush for one cycle -> scrub_busy high for 4 cycles (5 with SCRUB_CHECK_EN), all entries 0x00, count=0, rd_data=0x00 throughout, scrub_err=0.
- Assert flush with wr_valid and rd_ready both high -> neither handshake completes that cycle; flush re-asserted during SCRUB is ignored.
- Drop rst to 0 mid-scrub (scrub_idx=2) -> all outputs clear immediately; after release state=ACTIVE, wr_ready=1, count=0.
